// File: rtl/vga_timing_pkg.sv
`default_nettype none
// ============================================================================
// Module   : vga_timing_pkg
// Purpose  : 640x480@60 default raster timing, pipeline control word, helpers
// Revision : 1.0
// ============================================================================
package vga_timing_pkg;

    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_V_ACTIVE = 480;

    localparam int H_TOTAL      = 800;
    localparam int H_SYNC_START = 656;
    localparam int H_SYNC_END   = 751;

    localparam int V_TOTAL      = 525;
    localparam int V_SYNC_START = 490;
    localparam int V_SYNC_END   = 491;

    localparam logic [23:0] RGB_BLACK = 24'h000000;

    typedef struct packed {
        logic hs_n;
        logic vs_n;
        logic act;
    } vga_ctrl_t;

    localparam vga_ctrl_t CTRL_IDLE = '{hs_n: 1'b1, vs_n: 1'b1, act: 1'b0};

    function automatic vga_ctrl_t decode_ctrl(
        input int h,
        input int v,
        input int h_active,
        input int v_active,
        input int hs_start,
        input int hs_end,
        input int vs_start,
        input int vs_end
    );
        vga_ctrl_t c;
        c.hs_n = !((h >= hs_start) && (h <= hs_end));
        c.vs_n = !((v >= vs_start) && (v <= vs_end));
        c.act  = (h < h_active) && (v < v_active);
        return c;
    endfunction

endpackage
`default_nettype wire

// File: rtl/vga_frame_driver_if.sv
`default_nettype none
// ============================================================================
// Module   : vga_frame_driver_if
// Purpose  : Pixel raster / colour return path and DAC pin bundle
// Revision : 1.0
// ============================================================================
interface vga_frame_driver_if;

    logic        enable;
    logic [23:0] rgb_in;
    logic [9:0]  hcount;
    logic [9:0]  vcount;
    logic [7:0]  VGA_R;
    logic [7:0]  VGA_G;
    logic [7:0]  VGA_B;
    logic        VGA_HS;
    logic        VGA_VS;
    logic        VGA_BLANK_n;
    logic        VGA_SYNC_n;
    logic        VGA_CLK;
    logic        vblank_pulse;
    logic [15:0] frame_count;

    modport master (
        input  enable, rgb_in,
        output hcount, vcount, VGA_R, VGA_G, VGA_B, VGA_HS, VGA_VS,
               VGA_BLANK_n, VGA_SYNC_n, VGA_CLK, vblank_pulse, frame_count
    );

    modport slave (
        output enable, rgb_in,
        input  hcount, vcount, VGA_R, VGA_G, VGA_B, VGA_HS, VGA_VS,
               VGA_BLANK_n, VGA_SYNC_n, VGA_CLK, vblank_pulse, frame_count
    );

endinterface
`default_nettype wire

// File: rtl/vga_sync_delay.sv
`default_nettype none
// ============================================================================
// Module   : vga_sync_delay
// Purpose  : Pixel-enabled shift register aligning sync/blank with ppu latency
// Revision : 1.0
// ============================================================================
module vga_sync_delay
    import vga_timing_pkg::*;
#(
    parameter int DEPTH = 1
) (
    input  wire logic      clk,
    input  wire logic      reset,
    input  wire logic      pix_en,
    input  wire logic      flush,
    input  wire vga_ctrl_t din,
    output vga_ctrl_t      tap,
    output vga_ctrl_t      ctrl_out
);

    vga_ctrl_t r_stage [DEPTH];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) r_stage[i] <= CTRL_IDLE;
        end else if (flush) begin
            for (int i = 0; i < DEPTH; i++) r_stage[i] <= CTRL_IDLE;
        end else if (pix_en) begin
            r_stage[0] <= din;
            for (int i = 1; i < DEPTH; i++) r_stage[i] <= r_stage[i-1];
        end
    end

    // tap is the word about to enter the output stage on the next pix_en
    generate
        if (DEPTH == 1) begin : g_tap_input
            assign tap = din;
        end else begin : g_tap_stage
            assign tap = r_stage[DEPTH-2];
        end
    endgenerate

    assign ctrl_out = r_stage[DEPTH-1];

endmodule
`default_nettype wire

// File: rtl/vga_frame_driver.sv
`default_nettype none
// ============================================================================
// Module   : vga_frame_driver
// Purpose  : VGA raster timing master, ppu colour capture and DAC pin driver
// Revision : 1.0
// ============================================================================
module vga_frame_driver
    import vga_timing_pkg::*;
#(
    parameter int H_ACTIVE       = DEF_H_ACTIVE,
    parameter int H_FP           = H_SYNC_START - DEF_H_ACTIVE,
    parameter int H_SYNC         = H_SYNC_END - H_SYNC_START + 1,
    parameter int H_BP           = H_TOTAL - H_SYNC_END - 1,
    parameter int V_ACTIVE       = DEF_V_ACTIVE,
    parameter int V_FP           = V_SYNC_START - DEF_V_ACTIVE,
    parameter int V_SYNC         = V_SYNC_END - V_SYNC_START + 1,
    parameter int V_BP           = V_TOTAL - V_SYNC_END - 1,
    parameter int CLKS_PER_PIXEL = 2,
    parameter int PPU_LATENCY    = 0
) (
    input  wire logic          clk,
    input  wire logic          reset,
    vga_frame_driver_if.master bus
);

    localparam int c_h_total  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int c_v_total  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int c_hs_start = H_ACTIVE + H_FP;
    localparam int c_hs_end   = c_hs_start + H_SYNC - 1;
    localparam int c_vs_start = V_ACTIVE + V_FP;
    localparam int c_vs_end   = c_vs_start + V_SYNC - 1;
    localparam int c_div_w    = $clog2(CLKS_PER_PIXEL);

    localparam logic [c_div_w-1:0] c_div_last = c_div_w'(CLKS_PER_PIXEL - 1);
    localparam logic [c_div_w-1:0] c_div_half = c_div_w'(CLKS_PER_PIXEL / 2);

    logic [c_div_w-1:0] r_div;
    logic [9:0]         r_hcount;
    logic [9:0]         r_vcount;
    logic               r_vga_clk;
    logic [23:0]        r_rgb;
    logic               r_vblank_pulse;
    logic [15:0]        r_frame_count;

    logic      w_pix_en;
    logic      w_line_end;
    logic      w_frame_end;
    logic      w_vblank_entry;
    logic      w_flush;
    vga_ctrl_t w_ctrl;
    vga_ctrl_t w_tap;
    vga_ctrl_t w_ctrl_out;

    assign w_pix_en       = (r_div == c_div_last);
    assign w_line_end     = (r_hcount == 10'(c_h_total - 1));
    assign w_frame_end    = (r_vcount == 10'(c_v_total - 1));
    assign w_vblank_entry = w_line_end && (r_vcount == 10'(V_ACTIVE - 1));
    assign w_flush        = !bus.enable;

    assign w_ctrl = decode_ctrl(int'(r_hcount), int'(r_vcount), H_ACTIVE, V_ACTIVE,
                                c_hs_start, c_hs_end, c_vs_start, c_vs_end);

    vga_sync_delay #(
        .DEPTH (PPU_LATENCY + 1)
    ) u_sync_delay (
        .clk      (clk),
        .reset    (reset),
        .pix_en   (w_pix_en),
        .flush    (w_flush),
        .din      (w_ctrl),
        .tap      (w_tap),
        .ctrl_out (w_ctrl_out)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_div          <= '0;
            r_hcount       <= '0;
            r_vcount       <= '0;
            r_vga_clk      <= 1'b0;
            r_rgb          <= RGB_BLACK;
            r_vblank_pulse <= 1'b0;
            r_frame_count  <= '0;
        end else if (!bus.enable) begin
            r_div          <= '0;
            r_hcount       <= '0;
            r_vcount       <= '0;
            r_vga_clk      <= 1'b0;
            r_rgb          <= RGB_BLACK;
            r_vblank_pulse <= 1'b0;
        end else begin
            // DAC samples on its rising edge, which lands mid-pixel
            r_vga_clk      <= (r_div >= c_div_half);
            r_vblank_pulse <= 1'b0;
            if (w_pix_en) begin
                r_div <= '0;
                if (w_line_end) begin
                    r_hcount <= '0;
                    r_vcount <= w_frame_end ? 10'd0 : r_vcount + 10'd1;
                end else begin
                    r_hcount <= r_hcount + 10'd1;
                end
                r_rgb <= w_tap.act ? bus.rgb_in : RGB_BLACK;
                if (w_vblank_entry) begin
                    r_vblank_pulse <= 1'b1;
                    r_frame_count  <= r_frame_count + 16'd1;
                end
            end else begin
                r_div <= r_div + 1'b1;
            end
        end
    end

    assign bus.hcount       = r_hcount;
    assign bus.vcount       = r_vcount;
    assign bus.VGA_R        = r_rgb[23:16];
    assign bus.VGA_G        = r_rgb[15:8];
    assign bus.VGA_B        = r_rgb[7:0];
    assign bus.VGA_HS       = w_ctrl_out.hs_n;
    assign bus.VGA_VS       = w_ctrl_out.vs_n;
    assign bus.VGA_BLANK_n  = w_ctrl_out.act;
    assign bus.VGA_SYNC_n   = 1'b0;
    assign bus.VGA_CLK      = r_vga_clk;
    assign bus.vblank_pulse = r_vblank_pulse;
    assign bus.frame_count  = r_frame_count;

endmodule
`default_nettype wire

// File: tb/tb_vga_frame_driver.sv
`default_nettype none
// ============================================================================
// Module   : tb_vga_frame_driver
// Purpose  : Scoreboard bench for vga_frame_driver on a reduced raster
// Revision : 1.0
// ============================================================================
module tb_vga_frame_driver;

    localparam int HA = 16, HF = 4, HSW = 6, HB = 6;
    localparam int VA = 8,  VF = 2, VSW = 2, VB = 3;
    localparam int CPP = 2;
    localparam int HT = HA + HF + HSW + HB;
    localparam int VT = VA + VF + VSW + VB;
    localparam int FT = HT * VT;
    localparam int HS0 = HA + HF, HS1 = HS0 + HSW - 1;
    localparam int VS0 = VA + VF, VS1 = VS0 + VSW - 1;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic enable = 1'b0;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    vga_frame_driver_if if0 ();
    vga_frame_driver_if if1 ();

    function automatic logic [23:0] pat0(input int h, input int v);
        logic [7:0] hb, vb;
        hb = 8'(h);
        vb = 8'(v);
        return ((v % 2) == 1) ? {~hb, vb, 8'h5A} : 24'hFFFFFF;
    endfunction

    assign if0.enable = enable;
    assign if1.enable = enable;
    assign if0.rgb_in = pat0(int'(if0.hcount), int'(if0.vcount));
    // ppu with two pixel steps of latency: it is presenting the pixel from two columns ago
    assign if1.rgb_in = {8'((int'(if1.hcount) + HT - 2) % HT), 16'h0000};

    vga_frame_driver #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HSW), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VSW), .V_BP(VB),
        .CLKS_PER_PIXEL(CPP), .PPU_LATENCY(0)
    ) dut0 (
        .clk   (clk),
        .reset (reset),
        .bus   (if0)
    );

    vga_frame_driver #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HSW), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VSW), .V_BP(VB),
        .CLKS_PER_PIXEL(CPP), .PPU_LATENCY(2)
    ) dut1 (
        .clk   (clk),
        .reset (reset),
        .bus   (if1)
    );

    typedef struct {
        int          cyc;
        int          id;
        logic [31:0] exp;
    } exp_t;

    exp_t sb [$];
    int   n_checks = 0;
    int   n_errors = 0;

    function automatic string name_of(input int id);
        case (id)
            0:  return "hcount";
            1:  return "vcount";
            2:  return "VGA_HS";
            3:  return "VGA_VS";
            4:  return "VGA_BLANK_n";
            5:  return "VGA_R";
            6:  return "VGA_G";
            7:  return "VGA_B";
            8:  return "vblank_pulse";
            9:  return "frame_count";
            10: return "VGA_CLK";
            11: return "VGA_SYNC_n";
            12: return "lat2_VGA_HS";
            13: return "lat2_VGA_VS";
            14: return "lat2_VGA_BLANK_n";
            15: return "lat2_VGA_R";
            default: return "unknown";
        endcase
    endfunction

    function automatic logic [31:0] actual(input int id);
        case (id)
            0:  return 32'(if0.hcount);
            1:  return 32'(if0.vcount);
            2:  return 32'(if0.VGA_HS);
            3:  return 32'(if0.VGA_VS);
            4:  return 32'(if0.VGA_BLANK_n);
            5:  return 32'(if0.VGA_R);
            6:  return 32'(if0.VGA_G);
            7:  return 32'(if0.VGA_B);
            8:  return 32'(if0.vblank_pulse);
            9:  return 32'(if0.frame_count);
            10: return 32'(if0.VGA_CLK);
            11: return 32'(if0.VGA_SYNC_n);
            12: return 32'(if1.VGA_HS);
            13: return 32'(if1.VGA_VS);
            14: return 32'(if1.VGA_BLANK_n);
            15: return 32'(if1.VGA_R);
            default: return 32'hDEAD_BEEF;
        endcase
    endfunction

    task automatic push(input int c, input int id, input logic [31:0] e);
        exp_t x;
        x.cyc = c;
        x.id  = id;
        x.exp = e;
        sb.push_back(x);
    endtask

    // Expected pins when the output stage holds pixel index q (q < 0: nothing yet)
    task automatic push_pins(input int c, input int q, input int lat);
        int hq, vq;
        logic hs, vs, act;
        logic [23:0] rgb;
        hq = 0; vq = 0; hs = 1'b1; vs = 1'b1; act = 1'b0;
        if (q >= 0) begin
            hq  = q % HT;
            vq  = (q / HT) % VT;
            hs  = !((hq >= HS0) && (hq <= HS1));
            vs  = !((vq >= VS0) && (vq <= VS1));
            act = (hq < HA) && (vq < VA);
        end
        if (lat == 0) begin
            rgb = act ? pat0(hq, vq) : 24'h000000;
            push(c, 2, 32'(hs));
            push(c, 3, 32'(vs));
            push(c, 4, 32'(act));
            push(c, 5, 32'(rgb[23:16]));
            push(c, 6, 32'(rgb[15:8]));
            push(c, 7, 32'(rgb[7:0]));
        end else begin
            push(c, 12, 32'(hs));
            push(c, 13, 32'(vs));
            push(c, 14, 32'(act));
            push(c, 15, act ? 32'(hq % 256) : 32'd0);
        end
    endtask

    task automatic push_idle(input int c, input logic [15:0] fc);
        push(c, 0, 32'd0);
        push(c, 1, 32'd0);
        push_pins(c, -1, 0);
        push_pins(c, -1, 2);
        push(c, 8, 32'd0);
        push(c, 9, 32'(fc));
        push(c, 10, 32'd0);
        push(c, 11, 32'd0);
    endtask

    function automatic int frames_upto(input int n);
        return (n >= VA * HT) ? ((n - VA * HT) / FT + 1) : 0;
    endfunction

    // k counts clk edges since the first edge that sampled enable high
    task automatic push_run(input int c0, input int k0, input int nclk, input logic [15:0] fc_base);
        int k, n, n_ref;
        logic pulse;
        logic [15:0] fc;
        n_ref = k0 / CPP;
        for (int j = 0; j < nclk; j++) begin
            k     = k0 + j;
            n     = (k + 1) / CPP;
            pulse = (((k + 1) % CPP) == 0) && ((n % FT) == VA * HT);
            fc    = fc_base + 16'(frames_upto(n) - frames_upto(n_ref));
            push(c0 + j, 0, 32'(n % HT));
            push(c0 + j, 1, 32'((n / HT) % VT));
            push_pins(c0 + j, n - 1, 0);
            push_pins(c0 + j, n - 3, 2);
            push(c0 + j, 8, 32'(pulse));
            push(c0 + j, 9, 32'(fc));
            push(c0 + j, 10, 32'((k % CPP) >= (CPP / 2)));
            push(c0 + j, 11, 32'd0);
        end
    endtask

    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            exp_t x;
            logic [31:0] a;
            x = sb.pop_front();
            a = actual(x.id);
            n_checks++;
            if (x.cyc < cyc) begin
                n_errors++;
                $display("FAIL %s check for cyc=%0d not reached (now cyc=%0d)", name_of(x.id), x.cyc, cyc);
            end else if (a !== x.exp) begin
                n_errors++;
                $display("FAIL %s cyc=%0d actual=%0h expected=%0h", name_of(x.id), cyc, a, x.exp);
            end
        end
    end

    localparam int N_A = CPP * (2 * FT + 5 * HT + 10);
    localparam int N_5 = CPP * (3 * HT + 7);
    localparam int N_6 = CPP * (FT + VA * HT + 50) - N_5;
    localparam int N_7 = CPP * (VA * HT + 5);

    initial begin
        int c;
        // reset held, then released with the raster still disabled
        c = cyc;
        for (int i = 1; i <= 3; i++) push_idle(c + i, 16'd0);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        c = cyc;
        for (int i = 1; i <= 2; i++) push_idle(c + i, 16'd0);
        repeat (2) @(negedge clk);

        // two full frames plus a partial third, stopping at (10,5)
        enable = 1'b1;
        c = cyc;
        push_run(c + 1, 0, N_A, 16'd0);
        repeat (N_A) @(negedge clk);

        // drop enable for 10 clks mid-line
        enable = 1'b0;
        c = cyc;
        for (int i = 1; i <= 10; i++) push_idle(c + i, 16'd2);
        repeat (10) @(negedge clk);

        // restart from origin
        enable = 1'b1;
        c = cyc;
        push_run(c + 1, 0, N_5, 16'd2);
        repeat (N_5) @(negedge clk);

        // preset the frame counter to the wrap point
        c = cyc;
        #1 force dut0.r_frame_count = 16'hFFFF;
        #1 release dut0.r_frame_count;
        push_run(c + 1, N_5, N_6, 16'hFFFF);
        @(negedge clk);
        repeat (N_6 - 1) @(negedge clk);

        // asynchronous reset mid-line, away from any clk edge
        c = cyc;
        for (int i = 1; i <= 3; i++) push_idle(c + i, 16'd0);
        @(posedge clk);
        #2 reset = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        c = cyc;
        push_run(c + 1, 0, N_7, 16'd0);
        repeat (N_7) @(negedge clk);

        repeat (4) @(negedge clk);
        if (sb.size() != 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL scoreboard_drain actual=%0d pending required=0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/vga_frame_driver.md
Name: vga_frame_driver

Overview:
- Timing master and output stage on the far side of the pixel interface: generates the hcount/vcount raster that the ppu consumes, and samples the ppu's combinational 24-bit RGB back.
- Drives the DAC pins: registered R/G/B, HS, VS, BLANK_n, SYNC_n, VGA_CLK.
- Delays sync/blank to match the ppu pixel latency.
- Emits a once-per-frame vblank pulse and a frame counter for software.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, horizontal sync width
- H_BP, 48, horizontal back porch; line total 800
- V_ACTIVE, 480, visible lines
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width
- V_BP, 33, vertical back porch; frame total 525
- CLKS_PER_PIXEL, 2, clk cycles per pixel (>=2, even)
- PPU_LATENCY, 0, pixel steps between hcount/vcount change and matching rgb_in

Ports:
- clk  in  1  system clock (50 MHz)
- reset  in  1  asynchronous, active-low reset
- enable  in  1  raster run; low holds the raster at origin, blanked
- rgb_in  in  24  pixel colour from ppu, {R,G,B}
- hcount  out  10  current pixel column, 0..799
- vcount  out  10  current line, 0..524
- VGA_R, VGA_G, VGA_B  out  8 each  registered colour
- VGA_HS  out  1  horizontal sync, active low
- VGA_VS  out  1  vertical sync, active low
- VGA_BLANK_n  out  1  high in the active region
- VGA_SYNC_n  out  1  tied 0
- VGA_CLK  out  1  pixel clock to DAC
- vblank_pulse  out  1  one-clk pulse at vblank entry
- frame_count  out  16  frames completed, wraps

Behaviour:
- Reset values (async, reset=0):
  - div counter 0, hcount 0, vcount 0
  - VGA_R/G/B 0, VGA_HS 1, VGA_VS 1, VGA_BLANK_n 0, VGA_CLK 0
  - vblank_pulse 0, frame_count 0, delay line filled with {hs=1, vs=1, blank_n=0}
- Divider:
  - div counts 0..CLKS_PER_PIXEL-1 and wraps.
  - pix_en = (div == CLKS_PER_PIXEL-1).
  - VGA_CLK = registered (div >= CLKS_PER_PIXEL/2), so the DAC rising edge falls mid-pixel.
- Raster, updated only on pix_en:
  - hcount increments; at 799 it wraps to 0 and vcount increments.
  - vcount wraps 524 -> 0 when hcount wraps at 799.
- Decode from the pre-update hcount/vcount:
  - hs_n = !(656 <= h <= 751), i.e. H_ACTIVE+H_FP .. +H_SYNC-1.
  - vs_n = !(490 <= v <= 491).
  - act = (h < 640) && (v < 480).
- Delay line: on pix_en, {hs_n, vs_n, act} shifts through PPU_LATENCY+1 stages. The last stage drives VGA_HS, VGA_VS and VGA_BLANK_n.
- Colour: on pix_en, VGA_R/G/B load rgb_in when the delayed act stage entering output is 1, else 0.
  - Net latency from hcount change to pins is PPU_LATENCY+1 pixel steps, identical for colour and sync.
- vblank_pulse:
  - High for exactly one clk, on the clk where pix_en advances the raster from (799, 479) to (0, 480).
  - frame_count increments on that same clk and wraps 0xFFFF -> 0.
- enable=0:
  - On the next clk, div, hcount and vcount are forced to 0.
  - The delay line flushes to the reset pattern immediately.
  - Outputs are blanked with syncs high; no vblank_pulse.
- enable 0->1: the raster starts from (0, 0); the first pix_en occurs CLKS_PER_PIXEL clks later.
- Reset mid-frame: all state returns to reset values asynchronously. On release, the raster restarts at (0, 0) with no partial pulse.
- rgb_in is ignored outside the active region, regardless of value.

Decomposition:
- Package vga_timing_pkg holds:
  - timing constants (H_TOTAL=800, V_TOTAL=525, sync start/end)
  - RGB_BLACK = 24'h000000
  - a packed struct vga_ctrl_t {hs_n, vs_n, act}
- One sub-module, vga_sync_delay: a parameterised shift register of vga_ctrl_t with pixel enable and async active-low reset.

Test Plan:
- Reset then run 2 frames with CLKS_PER_PIXEL=2 -> hcount period 1600 clks, frame 840000 clks; hcount/vcount sequence wraps 799->0 and 524->0 exactly.
- Check HS/VS at PPU_LATENCY=0 -> VGA_HS low for 96 pixels starting 1 pixel step after hcount becomes 656; VGA_VS low for lines 490..491 only.
- rgb_in held at 24'hFFFFFF -> VGA_BLANK_n high for 640 pixels per line on lines 0..479. Colour pins are FF during active and 00 in porches and sync.
- PPU_LATENCY=2 with rgb_in = {hcount[7:0], 16'h0} delayed 2 pixel steps in the bench -> first active output pixel shows R=00, aligned with the VGA_BLANK_n rise.
- vblank_pulse -> exactly one clk wide per frame, at the (799,479)->(0,480) step; frame_count 0->1->2 over 2 frames. Preset frame_count to 0xFFFF by force -> wraps to 0.
- enable dropped at (300,200) for 10 clks, then raised -> hcount/vcount 0 within 1 clk, BLANK_n 0, HS/VS 1, no pulse. Restart from (0,0). Reset asserted mid-line -> identical recovery.
